// File: rtl/alu_mdu.sv
// ============================================================================
// Module   : alu_mdu
// Brief    : Combinational ALU plus a multi-cycle multiply/divide unit with
//            HI/LO result registers and a fixed-latency busy window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       aluOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] out,
  output logic             logicOutput,
  input  logic [2:0]       mdOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int HALF = WIDTH / 2;
  localparam int W2   = 2 * WIDTH;

  localparam logic [6:0] MUL_N = 7'(MUL_CYCLES);
  localparam logic [6:0] DIV_N = 7'(DIV_CYCLES);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [6:0]       count;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;

  logic             slt_s;
  logic             slt_u;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    product;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  assign busy  = (state != IDLE);
  assign slt_s = ($signed(A) < $signed(B));
  assign slt_u = (A < B);

  // ALU result and compare flag, independent of any MDU state
  always_comb begin
    out         = '0;
    logicOutput = 1'b0;
    case (aluOp)
      6'd0: out = A + B;
      6'd1: out = A - B;
      6'd2: out = A | B;
      6'd3: out = {B[HALF-1:0], A[HALF-1:0]};
      6'd4: logicOutput = (A == B);
      6'd5: out = A & B;
      6'd6: begin
        out         = {{(WIDTH-1){1'b0}}, slt_s};
        logicOutput = slt_s;
      end
      6'd7: begin
        out         = {{(WIDTH-1){1'b0}}, slt_u};
        logicOutput = slt_u;
      end
      default: begin
        out         = '0;
        logicOutput = 1'b0;
      end
    endcase
  end

  // Product and sign-magnitude division of the latched operands; the
  // magnitude form makes MIN / -1 fall out as lo = MIN, hi = 0 naturally
  always_comb begin
    ext_a   = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b   = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    product = ext_a * ext_b;
    neg_a   = op_signed & op_a[WIDTH-1];
    neg_b   = op_signed & op_b[WIDTH-1];
    mag_a   = neg_a ? (~op_a + 1'b1) : op_a;
    mag_b   = neg_b ? (~op_b + 1'b1) : op_b;
    q_mag   = (mag_b != '0) ? (mag_a / mag_b) : '0;
    r_mag   = (mag_b != '0) ? (mag_a % mag_b) : '0;
    quot    = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
    rem     = neg_a ? (~r_mag + 1'b1) : r_mag;
  end

  // MDU control: accepts ops only in IDLE, counts down the busy window and
  // commits HI/LO on the edge where the counter reaches zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdOp)
              MD_MULT, MD_MULTU: begin
                op_a      <= A;
                op_b      <= B;
                op_signed <= (mdOp == MD_MULT);
                count     <= MUL_N;
                state     <= MUL;
              end
              MD_DIV, MD_DIVU: begin
                op_a      <= A;
                op_b      <= B;
                op_signed <= (mdOp == MD_DIV);
                count     <= DIV_N;
                state     <= DIV;
              end
              MD_MTHI: hi <= A;
              MD_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        MUL: begin
          count <= count - 7'd1;
          if (count == 7'd1) begin
            state    <= IDLE;
            {hi, lo} <= product;
          end
        end
        DIV: begin
          count <= count - 7'd1;
          if (count == 7'd1) begin
            state <= IDLE;
            if (op_b != '0) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module   : tb_alu_mdu
// Brief    : Self-checking bench for alu_mdu with a HI/LO scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  aluOp;
  logic [31:0] A, B, out, hi, lo;
  logic        logicOutput, busy, start;
  logic [2:0]  mdOp;

  logic [5:0]  s_aluOp;
  logic [15:0] s_A, s_B, s_out, s_hi, s_lo;
  logic        s_flag, s_busy, s_start;
  logic [2:0]  s_mdOp;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .aluOp(aluOp), .A(A), .B(B), .out(out),
    .logicOutput(logicOutput), .mdOp(mdOp), .start(start), .busy(busy),
    .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .aluOp(s_aluOp), .A(s_A), .B(s_B), .out(s_out),
    .logicOutput(s_flag), .mdOp(s_mdOp), .start(s_start), .busy(s_busy),
    .hi(s_hi), .lo(s_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference ALU: returns {flag, result}
  function automatic logic [32:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    r = '0;
    f = 1'b0;
    case (op)
      6'd0: r = a + b;
      6'd1: r = a - b;
      6'd2: r = a | b;
      6'd3: r = {b[15:0], a[15:0]};
      6'd4: f = (a == b);
      6'd5: r = a & b;
      6'd6: begin f = ($signed(a) < $signed(b)); r = {31'd0, f}; end
      6'd7: begin f = (a < b); r = {31'd0, f}; end
      default: ;
    endcase
    return {f, r};
  endfunction

  // reference MDU: updates the modelled HI/LO
  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb2;
    sa  = $signed(a);
    sb2 = $signed(b);
    case (op)
      3'd1: begin
        sp   = longint'(sa) * longint'(sb2);
        m_hi = 32'(sp >>> 32);
        m_lo = 32'(sp);
      end
      3'd2: begin
        up   = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = a;
          m_hi = '0;
        end else begin
          m_lo = 32'(sa / sb2);
          m_hi = 32'(sa % sb2);
        end
      end
      3'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic alu_case(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] e;
    e = alu_ref(op, a, b);
    aluOp = op; A = a; B = b;
    #1;
    check($sformatf("alu op%0d out", op), out, e[31:0]);
    check($sformatf("alu op%0d flag", op), logicOutput, e[32]);
  endtask

  // Issue one MDU op, then count busy cycles and compare HI/LO from the queue
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    exp_t e;
    int   n;
    md_ref(op, a, b);
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.cyc = (op <= 3'd2) ? 5 : 10;
    sb.push_back(e);
    @(negedge clk);
    mdOp = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 3'd0; A = $urandom; B = $urandom;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    e = sb.pop_front();
    check({tag, " busy"}, 64'(n), 64'(e.cyc));
    check({tag, " hi"}, hi, e.hi);
    check({tag, " lo"}, lo, e.lo);
  endtask

  initial begin
    int n;
    exp_t e;
    reset = 1'b0; start = 1'b0; mdOp = 3'd0; aluOp = 6'd0; A = '0; B = '0;
    s_start = 1'b0; s_mdOp = 3'd0; s_aluOp = 6'd0; s_A = '0; s_B = '0;
    #2;
    check("reset busy", busy, 1'b0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ALU: spec points plus a few random operands per op
    aluOp = 6'd3; A = 32'h1234; B = 32'hABCD; #1;
    check("lui const", out, 32'hABCD_1234);
    aluOp = 6'd6; A = 32'hFFFF_FFFF; B = 32'd1; #1;
    check("slt -1<1", out, 32'd1);
    check("slt flag", logicOutput, 1'b1);
    aluOp = 6'd7; #1;
    check("sltu ff<1", out, 32'd0);
    aluOp = 6'd4; A = 32'd5; B = 32'd5; #1;
    check("equ flag", logicOutput, 1'b1);
    check("equ out", out, 32'd0);
    aluOp = 6'd9; A = 32'h1234_5678; B = 32'h1; #1;
    check("undef out", out, 32'd0);
    for (int i = 0; i < 3; i++)
      for (int op = 0; op < 8; op++)
        alu_case(6'(op), $urandom, (i == 2) ? 32'h8000_0000 : $urandom);

    // mthi / mtlo
    @(negedge clk);
    mdOp = 3'd5; A = 32'h11; start = 1'b1;
    @(negedge clk);
    mdOp = 3'd6; A = 32'h22;
    @(negedge clk);
    start = 1'b0; mdOp = 3'd0;
    m_hi = 32'h11; m_lo = 32'h22;
    check("mthi", hi, m_hi);
    check("mtlo", lo, m_lo);
    check("mt busy", busy, 1'b0);

    // none / reserved leave state alone
    mdOp = 3'd7; A = 32'hDEAD; start = 1'b1;
    @(negedge clk);
    mdOp = 3'd0;
    @(negedge clk);
    start = 1'b0;
    check("nop busy", busy, 1'b0);
    check("nop hi", hi, m_hi);
    check("nop lo", lo, m_lo);

    // spec multiply / divide points
    run_md(3'd1, 32'hFFFF_FFFF, 32'd2, "mult");
    check("mult hi const", hi, 32'hFFFF_FFFF);
    check("mult lo const", lo, 32'hFFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu hi const", hi, 32'h0000_0001);
    check("multu lo const", lo, 32'hFFFF_FFFE);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
    check("div lo const", lo, 32'hFFFF_FFFD);
    check("div hi const", hi, 32'hFFFF_FFFF);
    run_md(3'd4, 32'd7, 32'd0, "divu0");
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "divmin");
    check("divmin lo const", lo, 32'h8000_0000);
    run_md(3'd3, 32'd7, 32'hFFFF_FFFE, "div posneg");
    run_md(3'd3, 32'd5, 32'd0, "div0");

    // random mix
    for (int i = 0; i < 8; i++)
      run_md(3'(1 + (i % 4)), $urandom, (i == 5) ? 32'd3 : $urandom_range(1, 1000), "rand");

    // start while busy is ignored
    md_ref(3'd1, 32'd3, 32'd5);
    e.hi = m_hi; e.lo = m_lo; e.cyc = 5;
    sb.push_back(e);
    @(negedge clk);
    mdOp = 3'd1; A = 32'd3; B = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mdOp = 3'd0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin
        start = 1'b1; mdOp = 3'd4; A = 32'd100; B = 32'd7;
      end else begin
        start = 1'b0; mdOp = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; mdOp = 3'd0;
    e = sb.pop_front();
    check("ovl busy", 64'(n), 64'(e.cyc));
    check("ovl hi", hi, e.hi);
    check("ovl lo", lo, e.lo);
    @(negedge clk);
    check("ovl no queue", busy, 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    mdOp = 3'd5; A = 32'h11; start = 1'b1;
    @(negedge clk);
    mdOp = 3'd6; A = 32'h22;
    @(negedge clk);
    mdOp = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; mdOp = 3'd0;
    check("pre-rst hi", hi, 32'h11);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst async busy", busy, 1'b0);
    check("rst async hi", hi, 32'd0);
    check("rst async lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (12) @(negedge clk);
    check("post-rst busy", busy, 1'b0);
    check("post-rst hi", hi, 32'd0);
    check("post-rst lo", lo, 32'd0);
    run_md(3'd2, 32'd6, 32'd7, "after rst");

    // 16-bit instance, single-cycle multiply
    s_aluOp = 6'd3; s_A = 16'h1234; s_B = 16'hABCD;
    @(negedge clk);
    check("w16 lui", s_out, 16'hCD34);
    s_mdOp = 3'd2; s_A = 16'hFFFF; s_B = 16'hFFFF; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_mdOp = 3'd0;
    check("w16 busy1", s_busy, 1'b1);
    @(negedge clk);
    check("w16 busy0", s_busy, 1'b0);
    check("w16 hi", s_hi, 16'hFFFE);
    check("w16 lo", s_lo, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: operand, result, HI and LO width; legal values 8..64, even.
REQ-002 Parameter MUL_CYCLES, default 5: busy cycles for mult/multu; legal values 1..64.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for div/divu; legal values 1..64.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 aluOp  input  6  combinational op: 0 addu, 1 subu, 2 or, 3 lui, 4 equ, 5 and, 6 slt, 7 sltu; others undefined.
REQ-007 A  input  WIDTH  operand A, shared by ALU and MDU.
REQ-008 B  input  WIDTH  operand B, shared by ALU and MDU.
REQ-009 out  output  WIDTH  combinational ALU result.
REQ-010 logicOutput  output  1  combinational compare flag.
REQ-011 mdOp  input  3  MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-012 start  input  1  qualifies mdOp for one cycle.
REQ-013 busy  output  1  MDU operation in progress.
REQ-014 hi  output  WIDTH  HI register.
REQ-015 lo  output  WIDTH  LO register.

Function
REQ-016 ALU path SHALL be purely combinational, independent of clk, reset and MDU state.
REQ-017 addu/subu/or/and: out = A+B, A-B, A|B, A&B modulo 2^WIDTH; logicOutput = 0.
REQ-018 lui: out = {B[WIDTH/2-1:0], A[WIDTH/2-1:0]}; logicOutput = 0.
REQ-019 equ: logicOutput = (A == B); out = 0.
REQ-020 slt/sltu: out = 1 if A < B (signed / unsigned), else 0; logicOutput = out[0].
REQ-021 Undefined aluOp: out = 0, logicOutput = 0.
REQ-022 MDU FSM states: IDLE, MUL, DIV; busy = 1 exactly when the state is not IDLE.
REQ-023 In IDLE, start=1 with mult/multu SHALL latch A, B and signedness, load counter = MUL_CYCLES and enter MUL on the same edge.
REQ-024 In IDLE, start=1 with div/divu SHALL do the same with DIV_CYCLES and enter DIV.
REQ-025 Counter decrements every cycle; on the edge where it reaches 0 the FSM returns to IDLE and HI/LO are written on that same edge.
REQ-026 busy SHALL be high for exactly N consecutive cycles after the start edge (N = MUL_CYCLES or DIV_CYCLES); new HI/LO are visible in the first cycle busy is low.
REQ-027 mult/multu: {hi, lo} = 2*WIDTH-bit product of the latched operands, signed or unsigned.
REQ-028 div/divu: lo = quotient, hi = remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
REQ-029 Divisor 0: HI and LO SHALL be left unchanged, while busy timing is still honoured.
REQ-030 Signed MIN / -1: lo = MIN, hi = 0.
REQ-031 mthi/mtlo with start=1 in IDLE: hi (or lo) = A on that edge; busy stays 0.
REQ-032 start=1 while busy SHALL be ignored with no queueing; the in-flight op is unaffected by later changes to A or B.
REQ-033 start=0, or mdOp 0/7, SHALL leave all MDU state unchanged.

Reset
REQ-034 reset low SHALL immediately and asynchronously force state IDLE, counter 0, busy 0, hi 0 and lo 0, including mid-operation.
REQ-035 An operation aborted by reset SHALL never write HI/LO; the first start after reset release is accepted normally.

Verification
REQ-036 WIDTH=32, mult, A=0xFFFFFFFF, B=2, start 1 cycle -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; the same with multu -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 div, A=-7, B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu, A=7, B=0 -> busy 10 cycles, hi/lo unchanged.
REQ-038 mult started, then start=1 divu with new A/B on cycle 2 -> second op ignored, product of the first operands written at cycle 5.
REQ-039 reset pulled low on cycle 3 of a div with hi/lo preloaded via mthi/mtlo to 0x11/0x22 -> busy=0, hi=0, lo=0 immediately; no later update.
REQ-040 ALU sweep: lui A=0x1234, B=0xABCD -> out=0xABCD1234; slt A=-1, B=1 -> 1; sltu -> 0; equ A=B=5 -> logicOutput=1.
REQ-041 WIDTH=16, MUL_CYCLES=1: multu A=0xFFFF, B=0xFFFF -> busy exactly 1 cycle, hi=0xFFFE, lo=0x0001.
